// File: rtl/alu_issue_stage.sv
// Issue/retire stage around the external 4-bit ALU: operand fetch with EX forwarding,
// one EX register driving the ALU, and retire into an 8x4 register file plus flags.
module alu_issue_stage #(
    parameter int unsigned NREGS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_op,
    input  logic [2:0] in_rd,
    input  logic [2:0] in_rs1,
    input  logic [2:0] in_rs2,
    input  logic       in_imm_en,
    input  logic [3:0] in_imm,
    input  logic       hold,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_y,
    input  logic       alu_carry,
    input  logic       alu_ovf,
    input  logic       alu_zero,
    output logic       wb_valid,
    output logic [2:0] wb_rd,
    output logic [3:0] wb_data,
    output logic [2:0] flags,
    input  logic [2:0] dbg_addr,
    output logic [3:0] dbg_data
);

    logic       ex_valid_q;
    logic [2:0] ex_op_q;
    logic [2:0] ex_rd_q;
    logic [3:0] ex_a_q;
    logic [3:0] ex_b_q;
    logic [3:0] rf_q [NREGS];
    logic       wb_valid_q;
    logic [2:0] wb_rd_q;
    logic [3:0] wb_data_q;
    logic [2:0] flags_q;

    logic       fwd_ok;
    logic [3:0] src_a;
    logic [3:0] src_b;

    assign in_ready = ~hold;

    // Forwarding also covers the same-edge write/read collision: the retiring value is alu_y.
    assign fwd_ok = ex_valid_q && (ex_rd_q != 3'd0);

    always_comb begin
        src_a = 4'd0;
        if (fwd_ok && (ex_rd_q == in_rs1)) begin
            src_a = alu_y;
        end else if (in_rs1 != 3'd0) begin
            src_a = rf_q[in_rs1];
        end
    end

    always_comb begin
        src_b = 4'd0;
        if (in_imm_en) begin
            src_b = in_imm;
        end else if (fwd_ok && (ex_rd_q == in_rs2)) begin
            src_b = alu_y;
        end else if (in_rs2 != 3'd0) begin
            src_b = rf_q[in_rs2];
        end
    end

    // EX register; a bubble clears the ALU drive so it reads 0/0/000.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= 3'd0;
            ex_rd_q    <= 3'd0;
            ex_a_q     <= 4'd0;
            ex_b_q     <= 4'd0;
        end else if (!hold) begin
            if (in_valid) begin
                ex_valid_q <= 1'b1;
                ex_op_q    <= in_op;
                ex_rd_q    <= in_rd;
                ex_a_q     <= src_a;
                ex_b_q     <= src_b;
            end else begin
                ex_valid_q <= 1'b0;
                ex_op_q    <= 3'd0;
                ex_rd_q    <= 3'd0;
                ex_a_q     <= 4'd0;
                ex_b_q     <= 4'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rf_q[i] <= 4'd0;
            end
        end else if (!hold && ex_valid_q && (ex_rd_q != 3'd0)) begin
            rf_q[ex_rd_q] <= alu_y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 3'd0;
            wb_data_q  <= 4'd0;
            flags_q    <= 3'd0;
        end else if (!hold && ex_valid_q) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= ex_rd_q;
            wb_data_q  <= alu_y;
            flags_q    <= {alu_carry, alu_ovf, alu_zero};
        end else begin
            wb_valid_q <= 1'b0;
        end
    end

    assign alu_a    = ex_a_q;
    assign alu_b    = ex_b_q;
    assign alu_op   = ex_op_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign flags    = flags_q;
    assign dbg_data = (dbg_addr == 3'd0) ? 4'd0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU, architectural register model and a retire
// scoreboard, plus directed per-scenario checks.
module tb_alu_issue_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [2:0] in_rd;
    logic [2:0] in_rs1;
    logic [2:0] in_rs2;
    logic       in_imm_en;
    logic [3:0] in_imm;
    logic       hold;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_y;
    logic       alu_carry;
    logic       alu_ovf;
    logic       alu_zero;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [3:0] wb_data;
    logic [2:0] flags;
    logic [2:0] dbg_addr;
    logic [3:0] dbg_data;

    int errors = 0;
    int checks = 0;

    logic [3:0] model_rf [8];
    logic [9:0] exp_q [$];

    alu_issue_stage #(.NREGS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm_en (in_imm_en),
        .in_imm    (in_imm),
        .hold      (hold),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_y     (alu_y),
        .alu_carry (alu_carry),
        .alu_ovf   (alu_ovf),
        .alu_zero  (alu_zero),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .flags     (flags),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Returns {y, carry, ovf, zero}.
    function automatic logic [6:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] y;
        logic       c;
        logic       v;
        s = 5'd0;
        y = 4'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[3:0];
                c = s[4];
                v = (a[3] == b[3]) && (y[3] != a[3]);
            end
            3'b001: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                y = s[3:0];
                c = s[4];
                v = (a[3] != b[3]) && (y[3] != a[3]);
            end
            3'b010: y = a & b;
            3'b011: y = a | b;
            3'b100: y = a ^ b;
            3'b101: y = ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
            default: y = 4'd0;
        endcase
        return {y, c, v, (y == 4'd0)};
    endfunction

    always_comb {alu_y, alu_carry, alu_ovf, alu_zero} = alu_ref(alu_op, alu_a, alu_b);

    // Retire monitor: every wb_valid pulse must match the oldest expected retire.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected: got rd=%0d data=%h flags=%b, required no retire",
                         wb_rd, wb_data, flags);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({wb_rd, wb_data, flags} !== e) begin
                    errors++;
                    $display("FAIL retire: got rd=%0d data=%h flags=%b, required rd=%0d data=%h flags=%b",
                             wb_rd, wb_data, flags, e[9:7], e[6:3], e[2:0]);
                end
            end
        end
    end

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < 8; i++) model_rf[i] = 4'd0;
    endtask

    // Offers one instruction for one edge (hold must be low) and records its expected retire.
    task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic imm_en, input logic [3:0] imm);
        logic [3:0] a;
        logic [3:0] b;
        logic [6:0] r;
        in_valid  = 1'b1;
        in_op     = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm_en = imm_en;
        in_imm    = imm;
        a = (rs1 == 3'd0) ? 4'd0 : model_rf[rs1];
        b = imm_en ? imm : ((rs2 == 3'd0) ? 4'd0 : model_rf[rs2]);
        r = alu_ref(op, a, b);
        exp_q.push_back({rd, r});
        if (rd != 3'd0) model_rf[rd] = r[6:3];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({wb_valid, flags, alu_op, alu_a, alu_b} !== 15'd0) begin
            errors++;
            $display("FAIL reset_initial: got wb_valid=%b flags=%b op=%b a=%h b=%h, required all 0",
                     wb_valid, flags, alu_op, alu_a, alu_b);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_in_reset: got %b, required 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        send(3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 4'd9);
        send(3'b011, 3'd2, 3'd0, 3'd0, 1'b1, 4'd0);
        @(posedge clk);
        #3;
        dbg_addr = 3'd1;
        #1;
        checks++;
        if ({wb_valid, flags, dbg_data} !== {1'b1, 3'b001, 4'd9}) begin
            errors++;
            $display("FAIL pre_reset_state: got wb_valid=%b flags=%b r1=%h, required 1 001 9",
                     wb_valid, flags, dbg_data);
        end
        rst = 1'b1;
        clear_model();
        #1;
        checks++;
        if ({wb_valid, flags, alu_op} !== 7'd0) begin
            errors++;
            $display("FAIL reset_async: got wb_valid=%b flags=%b op=%b, required 0 000 000",
                     wb_valid, flags, alu_op);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            checks++;
            if (dbg_data !== 4'd0) begin
                errors++;
                $display("FAIL reset_rf r%0d: got %h, required 0", i, dbg_data);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        send(3'b000, 3'd1, 3'd0, 3'd0, 1'b1, 4'd7);
        send(3'b000, 3'd2, 3'd1, 3'd0, 1'b1, 4'd1);
        checks++;
        if ({alu_a, alu_b, alu_op} !== {4'd7, 4'd1, 3'b000}) begin
            errors++;
            $display("FAIL fwd_operands: got a=%h b=%h op=%b, required 7 1 000", alu_a, alu_b, alu_op);
        end
        checks++;
        if ({wb_valid, wb_data, flags} !== {1'b1, 4'd7, 3'b000}) begin
            errors++;
            $display("FAIL b2b_retire1: got v=%b data=%h flags=%b, required 1 7 000",
                     wb_valid, wb_data, flags);
        end
        idle(1);
        checks++;
        if ({wb_valid, wb_rd, wb_data, flags} !== {1'b1, 3'd2, 4'd8, 3'b010}) begin
            errors++;
            $display("FAIL b2b_retire2: got v=%b rd=%0d data=%h flags=%b, required 1 2 8 010",
                     wb_valid, wb_rd, wb_data, flags);
        end
    endtask

    task automatic test_sub();
        send(3'b001, 3'd3, 3'd2, 3'd1, 1'b0, 4'd0);
        checks++;
        if ({alu_a, alu_b, alu_op} !== {4'd8, 4'd7, 3'b001}) begin
            errors++;
            $display("FAIL sub_operands: got a=%h b=%h op=%b, required 8 7 001", alu_a, alu_b, alu_op);
        end
        idle(1);
        dbg_addr = 3'd3;
        #1;
        checks++;
        if ({wb_data, flags, dbg_data} !== {4'd1, 3'b110, 4'd1}) begin
            errors++;
            $display("FAIL sub_result: got data=%h flags=%b r3=%h, required 1 110 1",
                     wb_data, flags, dbg_data);
        end
    endtask

    task automatic test_r0_write();
        send(3'b100, 3'd0, 3'd1, 3'd0, 1'b1, 4'd7);
        idle(1);
        dbg_addr = 3'd0;
        #1;
        checks++;
        if ({wb_valid, wb_rd, wb_data, flags, dbg_data} !== {1'b1, 3'd0, 4'd0, 3'b001, 4'd0}) begin
            errors++;
            $display("FAIL r0_write: got v=%b rd=%0d data=%h flags=%b r0=%h, required 1 0 0 001 0",
                     wb_valid, wb_rd, wb_data, flags, dbg_data);
        end
        idle(1);
        checks++;
        if ({wb_valid, alu_a, alu_b, alu_op} !== 12'd0) begin
            errors++;
            $display("FAIL bubble: got v=%b a=%h b=%h op=%b, required all 0",
                     wb_valid, alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_hold();
        send(3'b101, 3'd4, 3'd1, 3'd2, 1'b0, 4'd0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({in_ready, wb_valid, alu_a, alu_b, alu_op} !== {2'b00, 4'd7, 4'd8, 3'b101}) begin
                errors++;
                $display("FAIL hold_cycle%0d: got rdy=%b v=%b a=%h b=%h op=%b, required 0 0 7 8 101",
                         i, in_ready, wb_valid, alu_a, alu_b, alu_op);
            end
            @(posedge clk);
            #1;
            checks++;
            if (wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_no_retire%0d: got wb_valid=%b, required 0", i, wb_valid);
            end
        end
        hold = 1'b0;
        idle(1);
        checks++;
        if ({wb_valid, wb_rd, wb_data, flags} !== {1'b1, 3'd4, 4'd0, 3'b001}) begin
            errors++;
            $display("FAIL hold_retire: got v=%b rd=%0d data=%h flags=%b, required 1 4 0 001",
                     wb_valid, wb_rd, wb_data, flags);
        end
    endtask

    task automatic test_reset_midflight();
        send(3'b000, 3'd5, 3'd0, 3'd0, 1'b1, 4'd3);
        #2;
        rst = 1'b1;
        clear_model();
        #2;
        rst = 1'b0;
        checks++;
        if ({alu_a, alu_b, alu_op} !== 11'd0) begin
            errors++;
            $display("FAIL midflight_ex_cleared: got a=%h b=%h op=%b, required 0 0 000",
                     alu_a, alu_b, alu_op);
        end
        for (int i = 0; i < 2; i++) begin
            idle(1);
            checks++;
            if (wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL midflight_no_retire%0d: got wb_valid=%b, required 0", i, wb_valid);
            end
        end
        dbg_addr = 3'd5;
        #1;
        checks++;
        if (dbg_data !== 4'd0) begin
            errors++;
            $display("FAIL midflight_r5: got %h, required 0", dbg_data);
        end
        dbg_addr = 3'd1;
        #1;
        checks++;
        if (dbg_data !== 4'd0) begin
            errors++;
            $display("FAIL midflight_r1_cleared: got %h, required 0", dbg_data);
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_rd     = 3'd0;
        in_rs1    = 3'd0;
        in_rs2    = 3'd0;
        in_imm_en = 1'b0;
        in_imm    = 4'd0;
        hold      = 1'b0;
        dbg_addr  = 3'd0;
        clear_model();

        test_reset();
        test_back_to_back();
        test_sub();
        test_r0_write();
        test_hold();
        test_reset_midflight();
        idle(2);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d retires outstanding, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Issue/retire stage wrapped around the 4-bit combinational ALU of the mini RISC-V core. It accepts decoded register-register and register-immediate instructions over a valid/ready handshake. It reads operands from an internal 8×4-bit register file, with forwarding from the instruction currently executing. It registers the operands and opcode into an execute register that drives the ALU, then retires the ALU result and flags into the register file and a status register.

## Interface
- `NREGS`, 8: register-file depth; fixed, `r0` hard-wired to zero.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: stage accepts this cycle; equals `~hold`.
- `in_op` in 3: ALU opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT; others give result 0).
- `in_rd` in 3: destination register.
- `in_rs1` in 3: source register A.
- `in_rs2` in 3: source register B.
- `in_imm_en` in 1: B operand is `in_imm` instead of `rs2`.
- `in_imm` in 4: immediate B operand.
- `hold` in 1: freeze the stage.
- `alu_a` out 4: registered ALU operand A.
- `alu_b` out 4: registered ALU operand B.
- `alu_op` out 3: registered ALU opcode.
- `alu_y` in 4: ALU result.
- `alu_carry` in 1: ALU carry flag.
- `alu_ovf` in 1: ALU overflow flag.
- `alu_zero` in 1: ALU zero flag.
- `wb_valid` out 1: a retire occurred at the last edge.
- `wb_rd` out 3: destination of the last retire.
- `wb_data` out 4: value of the last retire, as computed by the ALU.
- `flags` out 3: {carry, overflow, zero} of the last retired instruction.
- `dbg_addr` in 3: debug read address.
- `dbg_data` out 4: combinational register-file read; `r0` reads 0.

## Operation
- **Accept:** `in_valid & in_ready` at a rising edge. The instruction is loaded into the execute (EX) register: `ex_valid`=1, `ex_op`, `ex_rd`, `ex_a`, `ex_b`.
- **No accept:** at an edge with `~hold & ~in_valid`, `ex_valid` is loaded with 0 (a bubble).
- **Operand A:** `rf[rs1]`, or 0 if `rs1`=0.
  - Forwarding: if `ex_valid` and `ex_rd`==`rs1` and `ex_rd`≠0, A = `alu_y`.
- **Operand B:** `in_imm` if `in_imm_en`; otherwise `rs2` is resolved exactly like `rs1`.
- **ALU drive:** `alu_a`/`alu_b`/`alu_op` are driven directly from the EX register. They are 0/0/000 when `ex_valid`=0.
- **Retire:** at an edge with `ex_valid & ~hold`:
  - `rf[ex_rd]` ← `alu_y`, suppressed if `ex_rd`=0.
  - `flags` ← {`alu_carry`, `alu_ovf`, `alu_zero`}.
  - `wb_valid`←1, `wb_rd`←`ex_rd`, `wb_data`←`alu_y`.
  - A retire to `r0` still updates `flags` and the WB outputs. `wb_data` shows the ALU value; `rf[0]` stays 0.
- **Non-retire edges:** `wb_valid`←0. `wb_rd`, `wb_data` and `flags` hold.
- **Hold:** `hold`=1 freezes the EX register, register file and `flags`, and forces `in_ready`=0. ALU inputs stay stable, so `alu_y` stays stable.
- **Write/read collision:** if the instruction being accepted reads the register being retired at the same edge, forwarding supplies the new value. The register file is never read-after-write-bypassed separately.
- **Widths:** all data is 4 bits and arithmetic is done by the ALU only. The stage performs no arithmetic.

## Timing
- Reset values (async, immediate on `rst`=1):
  - `ex_valid`=0, `alu_a`=`alu_b`=0, `alu_op`=000.
  - All `rf` entries =0.
  - `flags`=000.
  - `wb_valid`=0, `wb_rd`=0, `wb_data`=0.
  - `in_ready`=`~hold` (combinational; not affected by `rst`).
- Latency:
  - Accept at edge E0.
  - ALU inputs valid in cycle E0→E1.
  - Retire at E1; `wb_valid`=1 and `flags` updated in cycle E1→E2.
  - `dbg_data` shows the new value from E1.
- Throughput: one instruction per cycle with back-to-back dependent instructions; no stall cycles.
- Reset mid-operation: the in-flight EX instruction is discarded and not retired. The register file clears.
- `hold` asserted with `ex_valid`=1: the retire is deferred to the first edge with `hold`=0.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `wb_valid`=0, `flags`=000, `alu_op`=000, `dbg_data`=0 for all 8 addresses.
- **Back-to-back forwarding:** accept ADD r1=r0+imm7, then immediately ADD r2=r1+imm1 →
  - retire 1: `wb_data`=0111, flags=000;
  - retire 2: `alu_a`=0111 (forwarded), `wb_data`=1000, flags=010 (signed overflow).
- **SUB:** r1=7, r2=8, then SUB r3=r2−r1 → `wb_data`=0001, flags=110; `dbg` r3 reads 1.
- **r0 write:** XOR r0=r1^imm0111 with r1=7 → `wb_valid`=1, `wb_data`=0000, flags=001; `dbg` r0 reads 0.
- **Hold:** accept SLT r4=r1<r2 (r1=7, r2=8, so 7 < −8 is false), then raise `hold` for 3 cycles →
  - `in_ready`=0 and `wb_valid`=0 throughout, `alu_a`/`alu_b` stable;
  - retire occurs on the edge after `hold` falls, `wb_data`=0000.
- **Reset mid-flight:** accept ADD r5=r0+imm3, then pulse `rst` before the next edge → no retire, r5 reads 0, `wb_valid` stays 0.
